// File: rtl/pio_in_pkg.sv
// Shared register map for the input PIO slave.
package pio_in_pkg;

  localparam int unsigned ADDR_W = 3;

  typedef enum logic [ADDR_W-1:0] {
    ADDR_DATA      = 3'd0,
    ADDR_RAW       = 3'd1,
    ADDR_IRQ_MASK  = 3'd2,
    ADDR_EDGE_CAP  = 3'd3,
    ADDR_RISE_EN   = 3'd4,
    ADDR_FALL_EN   = 3'd5,
    ADDR_DB_PERIOD = 3'd6
  } pio_addr_e;

endpackage

// File: rtl/pio_in_db_bit.sv
// One input bit: metastability synchroniser, debounce counter, debounced
// value and its one-cycle-delayed copy for edge detection.
module pio_in_db_bit
  import pio_in_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_bit,
  input  logic [CNT_W-1:0] db_period,
  output logic             sync_o,
  output logic             d_o,
  output logic             dp_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   dp_q, dp_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift chain, debounce counter and debounced value update.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_bit};
    dp_d   = deb_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    if (s == deb_q) begin
      cnt_d = '0;
    end else if ((db_period <= CNT_W'(1)) || (cnt_q >= db_period - CNT_W'(1))) begin
      // The period-0/1 test also guards against db_period-1 wrapping.
      deb_d = s;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Per-bit state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      dp_q   <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      dp_q   <= dp_d;
    end
  end

  assign sync_o = s;
  assign d_o    = deb_q;
  assign dp_o   = dp_q;

endmodule

// File: rtl/pio_in_edge_ctrl.sv
// Avalon-MM input PIO: per-bit debounced inputs, selectable edge capture
// with write-1-to-clear, and a masked level interrupt.
module pio_in_edge_ctrl
  import pio_in_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DB_DEFAULT  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq,
  output logic [31:0]       readdata
);

  logic [WIDTH-1:0] sync_vec, d_vec, dp_vec;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [CNT_W-1:0] db_period_q, db_period_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic             wr_en;
  logic             unused_wdata;

  // Write data bits beyond the register widths are ignored.
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_in_db_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_db_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_bit   (in_port[i]),
      .db_period(db_period_q),
      .sync_o   (sync_vec[i]),
      .d_o      (d_vec[i]),
      .dp_o     (dp_vec[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  // Register file writes and edge capture; a new edge beats a same-cycle clear.
  always_comb begin
    irq_mask_d  = irq_mask_q;
    rise_en_d   = rise_en_q;
    fall_en_d   = fall_en_q;
    db_period_d = db_period_q;
    edge_clr    = '0;
    edge_set    = (d_vec & ~dp_vec & rise_en_q) | (~d_vec & dp_vec & fall_en_q);
    if (wr_en) begin
      case (address)
        ADDR_IRQ_MASK:  irq_mask_d  = writedata[WIDTH-1:0];
        ADDR_EDGE_CAP:  edge_clr    = writedata[WIDTH-1:0];
        ADDR_RISE_EN:   rise_en_d   = writedata[WIDTH-1:0];
        ADDR_FALL_EN:   fall_en_d   = writedata[WIDTH-1:0];
        ADDR_DB_PERIOD: db_period_d = writedata[CNT_W-1:0];
        default: ;
      endcase
    end
    edge_cap_d = (edge_cap_q & ~edge_clr) | edge_set;
  end

  // Read mux, reloaded every cycle independent of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA:      readdata_d[WIDTH-1:0] = d_vec;
      ADDR_RAW:       readdata_d[WIDTH-1:0] = sync_vec;
      ADDR_IRQ_MASK:  readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP:  readdata_d[WIDTH-1:0] = edge_cap_q;
      ADDR_RISE_EN:   readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_FALL_EN:   readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_DB_PERIOD: readdata_d[CNT_W-1:0] = db_period_q;
      default:        readdata_d = '0;
    endcase
  end

  // Register file, capture and read data flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q  <= '0;
      edge_cap_q  <= '0;
      rise_en_q   <= '1;
      fall_en_q   <= '0;
      db_period_q <= CNT_W'(DB_DEFAULT);
      readdata_q  <= '0;
    end else begin
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      rise_en_q   <= rise_en_d;
      fall_en_q   <= fall_en_d;
      db_period_q <= db_period_d;
      readdata_q  <= readdata_d;
    end
  end

  assign irq      = |(edge_cap_q & irq_mask_q);
  assign readdata = readdata_q;

endmodule

// File: tb/tb_pio_in_edge_ctrl.sv
// Directed self-checking bench for pio_in_edge_ctrl (WIDTH=8, SYNC_STAGES=2).
module tb_pio_in_edge_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic        irq;
  logic [31:0] readdata;

  int n_checks = 0;
  int n_fail   = 0;

  pio_in_edge_ctrl #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .CNT_W      (16),
    .DB_DEFAULT (0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .irq       (irq),
    .readdata  (readdata)
  );

  always #5 clk = ~clk;

  // All bench activity happens 1ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    address    = a;
    writedata  = v;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address = a;
    @(posedge clk);
    #1;
    v = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0};
    reset_n = 1'b0;
    tick(3);
    n_checks++;
    if (readdata !== 32'h0) begin $display("FAIL reset_readdata got=%h exp=0", readdata); n_fail++; end
    n_checks++;
    if (irq !== 1'b0) begin $display("FAIL reset_irq got=%b exp=0", irq); n_fail++; end
    reset_n = 1'b1;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      n_checks++;
      if (v !== exp_tab[a]) begin $display("FAIL reset_reg%0d got=%h exp=%h", a, v, exp_tab[a]); n_fail++; end
    end
  endtask

  task automatic test_debounce_pass;
    logic [31:0] v;
    wr(3'd2, 32'h01);
    wr(3'd6, 32'd4);
    rd(3'd6, v);
    n_checks++;
    if (v !== 32'd4) begin $display("FAIL db_period_rb got=%h exp=4", v); n_fail++; end
    address = 3'd0;
    in_port = 8'h01;            // edge 0 is the one just passed
    tick(6);
    n_checks++;
    if (readdata !== 32'h0) begin $display("FAIL db_pass_data_e6 got=%h exp=0", readdata); n_fail++; end
    n_checks++;
    if (irq !== 1'b0) begin $display("FAIL db_pass_irq_e6 got=%b exp=0", irq); n_fail++; end
    tick(1);
    n_checks++;
    if (readdata !== 32'h1) begin $display("FAIL db_pass_data_e7 got=%h exp=1", readdata); n_fail++; end
    n_checks++;
    if (irq !== 1'b1) begin $display("FAIL db_pass_irq_e7 got=%b exp=1", irq); n_fail++; end
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h01) begin $display("FAIL db_pass_ecap got=%h exp=01", v); n_fail++; end
    wr(3'd3, 32'h01);
    n_checks++;
    if (irq !== 1'b0) begin $display("FAIL w1c_irq_drop got=%b exp=0", irq); n_fail++; end
    wr(3'd2, 32'h00);
    in_port = 8'h00;
    tick(10);
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h0) begin $display("FAIL db_pass_nofall got=%h exp=0", v); n_fail++; end
  endtask

  task automatic test_glitch;
    logic [31:0] v;
    wr(3'd6, 32'd4);
    address = 3'd1;
    in_port = 8'h08;
    tick(3);
    n_checks++;
    if (readdata !== 32'h08) begin $display("FAIL glitch_raw_high got=%h exp=08", readdata); n_fail++; end
    in_port = 8'h00;
    tick(3);
    n_checks++;
    if (readdata !== 32'h00) begin $display("FAIL glitch_raw_low got=%h exp=0", readdata); n_fail++; end
    tick(4);
    rd(3'd0, v);
    n_checks++;
    if (v !== 32'h0) begin $display("FAIL glitch_data got=%h exp=0", v); n_fail++; end
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h0) begin $display("FAIL glitch_ecap got=%h exp=0", v); n_fail++; end
  endtask

  task automatic test_fall_only;
    logic [31:0] v;
    wr(3'd4, 32'h00);
    wr(3'd5, 32'h80);
    wr(3'd6, 32'd0);
    in_port = 8'h80;
    tick(6);
    rd(3'd0, v);
    n_checks++;
    if (v !== 32'h80) begin $display("FAIL fall_data_hi got=%h exp=80", v); n_fail++; end
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h0) begin $display("FAIL fall_rise_ignored got=%h exp=0", v); n_fail++; end
    in_port = 8'h00;
    tick(6);
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h80) begin $display("FAIL fall_captured got=%h exp=80", v); n_fail++; end
    n_checks++;
    if (irq !== 1'b0) begin $display("FAIL fall_irq_masked got=%b exp=0", irq); n_fail++; end
    wr(3'd3, 32'hFF);
  endtask

  task automatic test_w1c_set_wins;
    logic [31:0] v;
    wr(3'd4, 32'hFF);
    wr(3'd5, 32'h00);
    wr(3'd6, 32'd0);
    in_port = 8'h05;
    tick(6);
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h05) begin $display("FAIL w1c_setup got=%h exp=05", v); n_fail++; end
    wr(3'd3, 32'h01);
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h04) begin $display("FAIL w1c_partial got=%h exp=04", v); n_fail++; end
    wr(3'd5, 32'h04);
    in_port = 8'h01;            // bit2 falls: s at edge 2, d at edge 3, capture at edge 4
    tick(3);
    wr(3'd3, 32'h04);           // write edge is edge 4
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h04) begin $display("FAIL set_wins got=%h exp=04", v); n_fail++; end
    wr(3'd3, 32'h04);
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'h00) begin $display("FAIL w1c_plain got=%h exp=0", v); n_fail++; end
  endtask

  task automatic test_period_shrink;
    wr(3'd5, 32'h00);
    wr(3'd6, 32'd100);
    address = 3'd0;
    in_port = 8'h41;
    tick(52);
    n_checks++;
    if (readdata !== 32'h01) begin $display("FAIL shrink_before got=%h exp=01", readdata); n_fail++; end
    wr(3'd6, 32'd10);
    address = 3'd0;
    tick(1);
    n_checks++;
    if (readdata !== 32'h01) begin $display("FAIL shrink_w1 got=%h exp=01", readdata); n_fail++; end
    tick(1);
    n_checks++;
    if (readdata !== 32'h41) begin $display("FAIL shrink_w2 got=%h exp=41", readdata); n_fail++; end
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    logic [31:0] exp_tab [8];
    exp_tab = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0};
    wr(3'd6, 32'd0);
    wr(3'd4, 32'hFF);
    wr(3'd5, 32'hFF);
    wr(3'd2, 32'hFF);
    in_port = 8'h00;
    tick(6);
    in_port = 8'hFF;
    tick(6);
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'hFF) begin $display("FAIL rmid_ecap got=%h exp=FF", v); n_fail++; end
    n_checks++;
    if (irq !== 1'b1) begin $display("FAIL rmid_irq_pre got=%b exp=1", irq); n_fail++; end
    wr(3'd6, 32'd100);
    in_port = 8'h00;
    tick(10);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (irq !== 1'b0) begin $display("FAIL rmid_irq_async got=%b exp=0", irq); n_fail++; end
    n_checks++;
    if (readdata !== 32'h0) begin $display("FAIL rmid_rd_async got=%h exp=0", readdata); n_fail++; end
    tick(2);
    reset_n = 1'b1;
    tick(1);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      n_checks++;
      if (v !== exp_tab[a]) begin $display("FAIL rmid_reg%0d got=%h exp=%h", a, v, exp_tab[a]); n_fail++; end
    end
    n_checks++;
    if (irq !== 1'b0) begin $display("FAIL rmid_irq_post got=%b exp=0", irq); n_fail++; end
  endtask

  initial begin
    test_reset;
    test_debounce_pass;
    test_glitch;
    test_fall_only;
    test_w1c_set_wins;
    test_period_shrink;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
